// File: rtl/int_wb_port_arbiter.sv
// int_wb_port_arbiter: shares the integer register-file write port between pipeline writeback and a long-latency result FIFO.
// Define WB_ARB_BYPASS_EN to write a long-latency result straight to the port when the FIFO is empty and the port is free.
module int_wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int XLEN         = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_pipe_wb_valid,
    input  logic [4:0]               i_pipe_wb_idx,
    input  logic [XLEN-1:0]          i_pipe_wb_data,
    input  logic                     i_lat_valid,
    output logic                     o_lat_ready,
    input  logic [4:0]               i_lat_idx,
    input  logic [XLEN-1:0]          i_lat_data,
    output logic                     o_wb_valid,
    output logic [4:0]               o_wb_idx,
    output logic [XLEN-1:0]          o_wb_data,
    output logic                     o_stall_pipe,
    output logic [31:0]              o_busy_mask,
    output logic [$clog2(DEPTH):0]   o_pending_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      q_idx  [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [AW:0]     wptr, rptr;
    logic [AW-1:0]   widx, ridx;
    logic [CW-1:0]   starve, starve_nxt;
    logic            empty, full, accept, enq, pipe_req, grant_fifo, bypass;

    assign widx            = wptr[AW-1:0];
    assign ridx            = rptr[AW-1:0];
    assign empty           = wptr == rptr;
    assign full            = (widx == ridx) && (wptr[AW] != rptr[AW]);
    assign o_lat_ready     = ~full;
    assign o_pending_count = wptr - rptr;
    assign accept          = i_lat_valid & ~full;
    assign pipe_req        = i_pipe_wb_valid & (i_pipe_wb_idx != 5'd0) & ~o_stall_pipe;
    assign grant_fifo      = ~empty & (o_stall_pipe | ~pipe_req);
`ifdef WB_ARB_BYPASS_EN
    assign bypass          = accept & (i_lat_idx != 5'd0) & empty & ~pipe_req;
`else
    assign bypass          = 1'b0;
`endif
    assign enq             = accept & (i_lat_idx != 5'd0) & ~bypass;

    // The head waits only while a pipe write holds the port; any pop or an empty FIFO restarts the wait.
    always_comb
        starve_nxt = (empty | grant_fifo) ? '0 :
                     (pipe_req && starve != CW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;

    always_comb begin
        o_busy_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (q_vld[i]) o_busy_mask[q_idx[i]] = 1'b1;
    end

    always_ff @(posedge i_clk)
        if (enq) begin
            q_idx[widx]  <= i_lat_idx;
            q_data[widx] <= i_lat_data;
        end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            q_vld        <= '0;
            starve       <= '0;
            o_stall_pipe <= 1'b0;
            o_wb_valid   <= 1'b0;
            o_wb_idx     <= '0;
            o_wb_data    <= '0;
        end else begin
            // Pop before push so a full-FIFO push into the freed slot keeps its valid bit.
            if (grant_fifo) begin
                q_vld[ridx] <= 1'b0;
                rptr        <= rptr + 1'b1;
            end
            if (enq) begin
                q_vld[widx] <= 1'b1;
                wptr        <= wptr + 1'b1;
            end
            starve       <= starve_nxt;
            o_stall_pipe <= ~empty & ~grant_fifo & (starve_nxt == CW'(STARVE_LIMIT));
            o_wb_valid   <= grant_fifo | pipe_req | bypass;
            if (grant_fifo) begin
                o_wb_idx  <= q_idx[ridx];
                o_wb_data <= q_data[ridx];
            end else if (pipe_req) begin
                o_wb_idx  <= i_pipe_wb_idx;
                o_wb_data <= i_pipe_wb_data;
            end else if (bypass) begin
                o_wb_idx  <= i_lat_idx;
                o_wb_data <= i_lat_data;
            end
        end
endmodule

// File: tb/tb_int_wb_port_arbiter.sv
// tb_int_wb_port_arbiter: directed checks of write-port arbitration, FIFO drain, starvation bubble and busy mask.
module tb_int_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_idx = '0;
    logic [31:0] pipe_data = '0;
    logic        lat_valid = 1'b0;
    logic        lat_ready;
    logic [4:0]  lat_idx = '0;
    logic [31:0] lat_data = '0;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        stall_pipe;
    logic [31:0] busy_mask;
    logic [1:0]  pending_count;
    int tests = 0;
    int failed = 0;

    int_wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(8), .XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pipe_wb_valid(pipe_valid), .i_pipe_wb_idx(pipe_idx), .i_pipe_wb_data(pipe_data),
        .i_lat_valid(lat_valid), .o_lat_ready(lat_ready), .i_lat_idx(lat_idx), .i_lat_data(lat_data),
        .o_wb_valid(wb_valid), .o_wb_idx(wb_idx), .o_wb_data(wb_data),
        .o_stall_pipe(stall_pipe), .o_busy_mask(busy_mask), .o_pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] i, input logic [31:0] d);
        pipe_valid = v; pipe_idx = i; pipe_data = d;
    endtask

    task automatic lat(input logic v, input logic [4:0] i, input logic [31:0] d);
        lat_valid = v; lat_idx = i; lat_data = d;
    endtask

    // Head blocked by back-to-back pipe writes: bubble after exactly 8 blocked cycles, head written next.
    task automatic starve_run(input logic [4:0] idx, input logic [31:0] d);
        pipe(1, 5'd1, 32'h100);
        lat(1, idx, d);
        tick;
        lat(0, 0, 0);
        check("starve_enq", busy_mask[idx], 1);
        for (int k = 1; k <= 8; k++) begin
            pipe(1, 5'd1, 32'h100 + k);
            tick;
            check($sformatf("starve_stall_%0d", k), stall_pipe, k == 8);
            check($sformatf("starve_pipe_%0d", k), {wb_valid, wb_idx}, {1'b1, 5'd1});
        end
        tick;
        check("starve_head_idx", {wb_valid, wb_idx}, {1'b1, idx});
        check("starve_head_data", wb_data, d);
        check("starve_stall_drop", stall_pipe, 0);
        check("starve_busy_clear", busy_mask, 0);
        pipe(0, 0, 0);
        tick;
    endtask

    initial begin
        #1;
        tick;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_idx_data", {wb_idx, wb_data}, 0);
        check("rst_stall", stall_pipe, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_count", pending_count, 0);
        check("rst_ready", lat_ready, 1);
        rst_n = 1'b1;
        tick;

        // Reset mid-stream with two buffered entries.
        pipe(1, 5'd1, 32'h1); lat(1, 5'd5, 32'h11);
        tick;
        pipe(1, 5'd2, 32'h2); lat(1, 5'd6, 32'h22);
        tick;
        pipe(0, 0, 0); lat(0, 0, 0);
        check("mid_count", pending_count, 2);
        check("mid_busy", busy_mask, 32'h60);
        check("mid_ready", lat_ready, 0);
        rst_n = 1'b0;
        tick;
        check("mid_rst_count", pending_count, 0);
        check("mid_rst_busy", busy_mask, 0);
        check("mid_rst_ready", lat_ready, 1);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            check($sformatf("mid_no_write_%0d", k), wb_valid, 0);
        end

        // Single long-latency result with idle pipe.
        lat(1, 5'd7, 32'hDEADBEEF);
        tick;
        lat(0, 0, 0);
`ifdef WB_ARB_BYPASS_EN
        check("x7_byp_valid", {wb_valid, wb_idx}, {1'b1, 5'd7});
        check("x7_byp_data", wb_data, 32'hDEADBEEF);
        check("x7_byp_busy", busy_mask, 0);
        tick;
        check("x7_byp_once", wb_valid, 0);
`else
        check("x7_c1_valid", wb_valid, 0);
        check("x7_c1_busy", busy_mask, 32'h80);
        check("x7_c1_count", pending_count, 1);
        tick;
        check("x7_c2_valid", {wb_valid, wb_idx}, {1'b1, 5'd7});
        check("x7_c2_data", wb_data, 32'hDEADBEEF);
        check("x7_c2_busy", busy_mask, 0);
        check("x7_c2_count", pending_count, 0);
        tick;
        check("x7_once", wb_valid, 0);
`endif

        // Pipe x1..x4 back-to-back, x9 drains into the first idle slot.
        lat(1, 5'd9, 32'h5);
        for (int k = 1; k <= 4; k++) begin
            pipe(1, 5'(k), 32'h1000 + k);
            tick;
            lat(0, 0, 0);
            check($sformatf("seq_idx_%0d", k), {wb_valid, wb_idx}, {1'b1, 5'(k)});
            check($sformatf("seq_busy9_%0d", k), busy_mask[9], 1);
        end
        pipe(0, 0, 0);
        tick;
        check("seq_idx_9", {wb_valid, wb_idx}, {1'b1, 5'd9});
        check("seq_data_9", wb_data, 32'h5);
        check("seq_busy9_clear", busy_mask[9], 0);
        check("seq_no_stall", stall_pipe, 0);
        tick;

        starve_run(5'd10, 32'hA);
        starve_run(5'd11, 32'hB);

        // Fill the FIFO, then offer a third result while the head pops.
        pipe(1, 5'd2, 32'h2); lat(1, 5'd12, 32'hC);
        tick;
        check("full_c1_count", pending_count, 1);
        lat(1, 5'd13, 32'hD);
        tick;
        check("full_c2_count", pending_count, 2);
        pipe(0, 0, 0); lat(1, 5'd14, 32'hE);
        #1;
        check("full_ready_low", lat_ready, 0);
        tick;
        check("full_pop12", {wb_valid, wb_idx, wb_data}, {1'b1, 5'd12, 32'hC});
        check("full_c3_count", pending_count, 1);
        check("full_ready_back", lat_ready, 1);
        tick;
        lat(0, 0, 0);
        check("full_pop13", {wb_valid, wb_idx, wb_data}, {1'b1, 5'd13, 32'hD});
        check("full_c4_count", pending_count, 1);
        check("full_c4_busy", busy_mask, 32'h4000);
        tick;
        check("full_pop14", {wb_valid, wb_idx, wb_data}, {1'b1, 5'd14, 32'hE});
        check("full_c5_count", pending_count, 0);
        tick;
        check("full_no_dup", wb_valid, 0);

        // Index-zero requests leave the port idle, letting a buffered head drain.
        pipe(1, 5'd3, 32'h3); lat(1, 5'd15, 32'hF);
        tick;
        check("x0_setup_count", pending_count, 1);
        pipe(1, 5'd0, 32'h77); lat(1, 5'd0, 32'h99);
        tick;
        check("x0_drain", {wb_valid, wb_idx, wb_data}, {1'b1, 5'd15, 32'hF});
        check("x0_drain_count", pending_count, 0);
        check("x0_drain_busy", busy_mask, 0);
        tick;
        pipe(0, 0, 0); lat(0, 0, 0);
        check("x0_no_write", wb_valid, 0);
        check("x0_hold_idx", {wb_idx, wb_data}, {5'd15, 32'hF});
        check("x0_count", pending_count, 0);
        check("x0_busy", busy_mask, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
